// File: rtl/neuron_sched_pkg.sv
// Shared types and defaults for the threshold scan scheduler.
package neuron_sched_pkg;

    localparam int unsigned WIDTH          = 8;
    localparam int unsigned DEF_N_NEURONS  = 8;
    localparam logic [WIDTH-1:0] DEF_REST_VAL = 8'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/magnitude_comparator.sv
// Shared 8-bit combinational magnitude comparator (lives outside the scheduler).
module magnitude_comparator #(
    parameter int unsigned WIDTH = neuron_sched_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_lt,
    output logic             o_eq,
    output logic             o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/neuron_pot_regfile.sv
// Membrane-potential register bank: one write port, one clear port, async read.
module neuron_pot_regfile #(
    parameter int unsigned N_NEURONS = neuron_sched_pkg::DEF_N_NEURONS,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned WIDTH     = neuron_sched_pkg::WIDTH,
    parameter logic [WIDTH-1:0] REST_VAL = neuron_sched_pkg::DEF_REST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_pot [N_NEURONS];

    // Write beats clear on the same index; indices outside the bank match nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_NEURONS); i++) begin
            if (rst) begin
                r_pot[i] <= REST_VAL;
            end else if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                r_pot[i] <= i_wr_data;
            end else if (i_clr_en && (i_clr_idx == IDX_W'(i))) begin
                r_pot[i] <= REST_VAL;
            end
        end
    end

    assign o_rd_data = r_pot[i_rd_idx];

endmodule

// File: rtl/threshold_scan_scheduler.sv
// Scans the potential bank through a shared comparator and emits spike events.
module threshold_scan_scheduler #(
    parameter int unsigned N_NEURONS = neuron_sched_pkg::DEF_N_NEURONS,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned WIDTH     = neuron_sched_pkg::WIDTH,
    parameter logic [WIDTH-1:0] REST_VAL = neuron_sched_pkg::DEF_REST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] thresh,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             spk_valid,
    input  logic             spk_ready,
    output logic [IDX_W-1:0] spk_idx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   spike_count
);

    import neuron_sched_pkg::*;

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_thr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ge;
    logic             w_last;
    logic             w_handshake;

    assign w_ge        = cmp_gt | cmp_eq;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_handshake = (r_state == EMIT) && spk_ready;

    neuron_pot_regfile #(
        .N_NEURONS (N_NEURONS),
        .IDX_W     (IDX_W),
        .WIDTH     (WIDTH),
        .REST_VAL  (REST_VAL)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en),
        .i_wr_idx  (wr_idx),
        .i_wr_data (wr_data),
        .i_clr_en  (w_handshake),
        .i_clr_idx (r_idx),
        .i_rd_idx  (r_idx),
        .o_rd_data (cmp_a)
    );

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        spk_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = COMPARE;
            end
            COMPARE: begin
                if (w_ge)        w_state_nxt = EMIT;
                else if (w_last) w_state_nxt = DONE;
            end
            EMIT: begin
                spk_valid = 1'b1;
                if (spk_ready) w_state_nxt = w_last ? DONE : COMPARE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, scan index, sampled threshold and spike counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_thr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && start) begin
                r_thr <= thresh;
                r_idx <= '0;
                r_cnt <= '0;
            end else if ((r_state == COMPARE) && !w_ge && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end else if (w_handshake) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (!w_last) r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Comparator sanity: exactly one relation flag while a compare is in flight.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == COMPARE)) begin
            assert ($onehot({cmp_lt, cmp_eq, cmp_gt}))
                else $error("comparator flags not one-hot");
        end
    end

    assign cmp_b       = r_thr;
    assign spk_idx     = r_idx;
    assign spike_count = r_cnt;

endmodule

// File: tb/tb_threshold_scan_scheduler.sv
// Self-checking bench: behavioural scan model plus directed and random scans.
module tb_threshold_scan_scheduler;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int W  = 8;
    localparam int REST = 0;

    logic          clk = 1'b0;
    logic          rst, start, wr_en, spk_ready;
    logic [W-1:0]  thresh, wr_data, cmp_a, cmp_b;
    logic [IW-1:0] wr_idx, spk_idx;
    logic          cmp_lt, cmp_eq, cmp_gt;
    logic          spk_valid, busy, done;
    logic [IW:0]   spike_count;

    always #5 clk = ~clk;

    threshold_scan_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .thresh(thresh),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
        .busy(busy), .done(done), .spike_count(spike_count)
    );

    magnitude_comparator u_cmp (
        .i_a(cmp_a), .i_b(cmp_b), .o_lt(cmp_lt), .o_eq(cmp_eq), .o_gt(cmp_gt)
    );

    // Reference model: scan position, outstanding event, finishing flag.
    int m_pot [N];
    bit m_active, m_pending, m_finish;
    int m_pos, m_thr, m_count;

    int checks = 0, errors = 0, cyc = 0;
    int start_cyc, done_cyc;
    bit done_seen;
    int log_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_active = 0; m_pending = 0; m_finish = 0;
            m_pos = 0; m_thr = 0; m_count = 0;
            for (int i = 0; i < N; i++) m_pot[i] = REST;
        end else begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_pos = 0; m_thr = int'(thresh); m_count = 0;
                    start_cyc = cyc;
                end
            end else if (m_finish) begin
                m_active = 0; m_finish = 0;
            end else if (m_pending) begin
                if (spk_ready) begin
                    m_pot[m_pos] = REST;
                    m_count++;
                    m_pending = 0;
                    if (m_pos == N - 1) m_finish = 1; else m_pos++;
                end
            end else begin
                if (m_pot[m_pos] >= m_thr) m_pending = 1;
                else if (m_pos == N - 1)   m_finish = 1;
                else                       m_pos++;
            end
            if (wr_en && int'(wr_idx) < N) m_pot[wr_idx] = int'(wr_data);
        end
    endtask

    // One clock: compare DUT against model mid-cycle, then advance the model.
    task automatic step();
        @(negedge clk);
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_finish));
        chk("spk_valid", int'(spk_valid), int'(m_pending));
        if (m_pending) chk("spk_idx", int'(spk_idx), m_pos);
        chk("spike_count", int'(spike_count), m_count);
        chk("cmp_b", int'(cmp_b), m_thr);
        if (m_active && !m_pending && !m_finish) chk("cmp_a", int'(cmp_a), m_pot[m_pos]);
        if (!rst && spk_valid && spk_ready) log_q.push_back(int'(spk_idx));
        if (!rst && done) begin done_seen = 1; done_cyc = cyc; end
        model_update();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; start = 0; wr_en = 0; wr_idx = '0; wr_data = '0;
    endtask

    task automatic load_pot(input int idx, input int val);
        wr_en = 1; wr_idx = IW'(idx); wr_data = W'(val);
        step();
        wr_en = 0;
    endtask

    task automatic start_scan(input int thr);
        log_q.delete();
        done_seen = 0;
        start = 1; thresh = W'(thr);
        step();
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin step(); n++; end
        if (!done_seen) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!spk_valid && n < budget) begin step(); n++; end
        chk("valid_seen", int'(spk_valid), 1);
    endtask

    task automatic chk_log(input string name, input int exp_q [$]);
        chk({name, "_nspk"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk({name, "_spk"}, log_q[i], exp_q[i]);
    endtask

    initial begin
        int stable;
        quiet(); thresh = '0; spk_ready = 1;
        rst = 1;
        @(posedge clk); #1;
        step();
        rst = 0;
        // Reset state pinned literally.
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(spk_valid), 0);
        chk("rst_cnt", int'(spike_count), 0);
        chk("rst_cmp_a", int'(cmp_a), 0);
        chk("rst_cmp_b", int'(cmp_b), 0);

        // Ascending ramp, threshold 45.
        for (int i = 0; i < N; i++) load_pot(i, 10 * (i + 1));
        start_scan(45);
        wait_done(40);
        chk("t1_latency", done_cyc - start_cyc, 13);
        chk_log("t1", '{4, 5, 6, 7});
        chk("t1_count", int'(spike_count), 4);
        for (int i = 4; i < N; i++) chk("t1_model_pot", m_pot[i], 0);
        start_scan(1);
        wait_done(40);
        chk_log("t1_resid", '{0, 1, 2, 3});

        // All below threshold.
        for (int i = 0; i < N; i++) load_pot(i, 44);
        start_scan(45);
        wait_done(40);
        chk("t2_latency", done_cyc - start_cyc, 9);
        chk("t2_nspk", log_q.size(), 0);
        chk("t2_count", int'(spike_count), 0);

        // Equality spike with 5 stalled cycles.
        for (int i = 0; i < N; i++) load_pot(i, (i == 2) ? 45 : 0);
        spk_ready = 0;
        start_scan(45);
        wait_valid(20);
        stable = 0;
        for (int k = 0; k < 5; k++) begin
            stable += int'(spk_valid && spk_idx == 3'd2);
            step();
        end
        spk_ready = 1;
        stable += int'(spk_valid && spk_idx == 3'd2);
        step();
        chk("t3_stable", stable, 6);
        wait_done(40);
        chk("t3_latency", done_cyc - start_cyc, 15);
        chk_log("t3", '{2});

        // Threshold change and start pulse mid-scan are ignored.
        for (int i = 0; i < N; i++) load_pot(i, 10 * (i + 1));
        start_scan(45);
        step(); step(); step();
        thresh = '0; start = 1;
        step();
        start = 0;
        wait_done(40);
        chk("t4_latency", done_cyc - start_cyc, 13);
        chk_log("t4", '{4, 5, 6, 7});
        step(); step(); step();
        chk("t4_idle", int'(busy), 0);

        // Write colliding with spike clear on the handshake cycle.
        for (int i = 0; i < N; i++) load_pot(i, (i == 3) ? 50 : 0);
        spk_ready = 0;
        start_scan(45);
        wait_valid(20);
        spk_ready = 1; wr_en = 1; wr_idx = 3'd3; wr_data = 8'd99;
        step();
        wr_en = 0;
        wait_done(40);
        chk("t5_model_pot3", m_pot[3], 99);
        start_scan(99);
        wait_done(40);
        chk_log("t5", '{3});

        // Reset while an event is pending.
        load_pot(0, 200);
        spk_ready = 0;
        start_scan(100);
        wait_valid(20);
        rst = 1;
        step();
        rst = 0;
        chk("t6_valid", int'(spk_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        done_seen = 0;
        step(); step();
        chk("t6_no_done", int'(done_seen), 0);
        spk_ready = 1;
        load_pot(5, 7);
        start_scan(1);
        wait_done(40);
        chk("t6_latency", done_cyc - start_cyc, 10);
        chk_log("t6", '{5});

        // Randomised scans with stalls, writes, stray starts and rare resets.
        for (int s = 0; s < 40; s++) begin
            int n;
            for (int k = 0; k < 4; k++) begin
                wr_en = ($urandom_range(0, 1) == 1);
                wr_idx = IW'($urandom_range(0, N - 1));
                wr_data = W'($urandom_range(0, 255));
                spk_ready = 1;
                step();
            end
            wr_en = 0;
            case ($urandom_range(0, 5))
                0:       thresh = 8'd0;
                1:       thresh = 8'd255;
                default: thresh = W'($urandom_range(0, 255));
            endcase
            start = 1;
            step();
            start = 0;
            n = 0;
            while (m_active && n < 300) begin
                spk_ready = ($urandom_range(0, 9) < 7);
                wr_en = ($urandom_range(0, 4) == 0);
                wr_idx = IW'($urandom_range(0, N - 1));
                wr_data = W'($urandom_range(0, 255));
                start = ($urandom_range(0, 7) == 0);
                thresh = W'($urandom_range(0, 255));
                rst = ($urandom_range(0, 199) == 0);
                step();
                n++;
            end
            quiet();
            if (m_active) chk("rand_timeout", 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
